// File: rtl/alu_seq16.sv
// Nibble-serial sequencer that runs W-bit operations (W = 4*NIBBLES) on an
// external 4-bit ALU. It chains carries between nibbles, assembles the wide
// result and produces whole-word flags behind a start/busy/done handshake.
module alu_seq16 #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [2:0]             alu_op,
  input  logic [3:0]             alu_r,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  input  logic                   alu_sign,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   zero,
  output logic                   carry,
  output logic                   sign,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [W-1:0]     a_lat, a_lat_n;
  logic [W-1:0]     b_lat, b_lat_n;
  logic [2:0]       op_lat, op_lat_n;
  logic             cin_lat, cin_lat_n;
  logic             carry_reg, carry_reg_n;
  logic             zero_acc, zero_acc_n;
  logic [W-1:0]     result_n;
  logic             zero_n, carry_n, sign_n, busy_n, done_n;

  // Word zero is recomputed from captured nibbles and word sign is taken from
  // the captured top nibble, so the ALU's own zero/sign outputs are not needed.
  logic [1:0] unused_alu_flags;
  assign unused_alu_flags = {alu_zero, alu_sign};

  // Drive the ALU with the current nibble; logic ops never see a chained carry.
  always_comb begin
    alu_a   = a_lat[{idx, 2'b00} +: 4];
    alu_b   = b_lat[{idx, 2'b00} +: 4];
    alu_op  = op_lat;
    alu_cin = (idx == '0) ? cin_lat : (op_lat[2] ? 1'b0 : carry_reg);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    a_lat_n     = a_lat;
    b_lat_n     = b_lat;
    op_lat_n    = op_lat;
    cin_lat_n   = cin_lat;
    carry_reg_n = carry_reg;
    zero_acc_n  = zero_acc;
    result_n    = result;
    zero_n      = zero;
    carry_n     = carry;
    sign_n      = sign;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_lat_n     = a;
          b_lat_n     = b;
          op_lat_n    = op;
          cin_lat_n   = cin;
          idx_n       = '0;
          carry_reg_n = 1'b0;
          zero_acc_n  = 1'b1;
          result_n    = '0;
          zero_n      = 1'b0;
          carry_n     = 1'b0;
          sign_n      = 1'b0;
          busy_n      = 1'b1;
          state_n     = RUN;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        result_n[{idx, 2'b00} +: 4] = alu_r;
        carry_reg_n = alu_carry;
        zero_acc_n  = zero_acc & (alu_r == 4'h0);
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = DONE;
          done_n  = 1'b1;
          carry_n = op_lat[2] ? 1'b0 : alu_carry;
          sign_n  = alu_r[3];
          zero_n  = zero_acc_n;
        end else begin
          idx_n  = idx + IDX_W'(1);
          busy_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      op_lat    <= '0;
      cin_lat   <= 1'b0;
      carry_reg <= 1'b0;
      zero_acc  <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      sign      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      a_lat     <= a_lat_n;
      b_lat     <= b_lat_n;
      op_lat    <= op_lat_n;
      cin_lat   <= cin_lat_n;
      carry_reg <= carry_reg_n;
      zero_acc  <= zero_acc_n;
      result    <= result_n;
      zero      <= zero_n;
      carry     <= carry_n;
      sign      <= sign_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: a 4-bit ALU model attached to a 16-bit and an 8-bit
// sequencer, with directed cases plus random operations against a word-level model.
module tb_alu_seq16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, cin, stub;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [3:0]  alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_zero, alu_carry, alu_sign;
  logic [15:0] result;
  logic        zero, carry, sign, busy, done;
  logic [4:0]  alu_out;

  logic        start2, cin2;
  logic [2:0]  op2;
  logic [7:0]  a2, b2;
  logic [3:0]  alu2_a, alu2_b, alu2_r;
  logic [2:0]  alu2_op;
  logic        alu2_cin, alu2_zero, alu2_carry, alu2_sign;
  logic [7:0]  result2;
  logic        zero2, carry2, sign2, busy2, done2;
  logic [4:0]  alu2_out;

  int checks = 0;
  int errors = 0;

  alu_seq16 #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .result(result), .zero(zero), .carry(carry), .sign(sign), .busy(busy), .done(done)
  );

  alu_seq16 #(.NIBBLES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2), .cin(cin2),
    .alu_a(alu2_a), .alu_b(alu2_b), .alu_cin(alu2_cin), .alu_op(alu2_op),
    .alu_r(alu2_r), .alu_zero(alu2_zero), .alu_carry(alu2_carry), .alu_sign(alu2_sign),
    .result(result2), .zero(zero2), .carry(carry2), .sign(sign2), .busy(busy2), .done(done2)
  );

  // 4-bit ALU: {carry, result}. Logic ops report carry=1 so masking is visible.
  function automatic logic [4:0] alu4(input logic [2:0] o, input logic [3:0] x, y, input logic c);
    logic [3:0] xx, yy;
    if (o[2]) begin
      case (o[1:0])
        2'd0:    return {1'b1, x & y};
        2'd1:    return {1'b1, x | y};
        2'd2:    return {1'b1, x ^ y};
        default: return {1'b1, ~(x | y)};
      endcase
    end
    xx = o[1] ? ~x : x;
    yy = o[0] ? ~y : y;
    return {1'b0, xx} + {1'b0, yy} + 5'(c);
  endfunction

  // Whole-word reference: {carry, result}.
  function automatic logic [16:0] ref_word(input logic [2:0] o, input logic [15:0] x, y, input logic c);
    logic [15:0] xx, yy;
    if (o[2]) begin
      case (o[1:0])
        2'd0:    return {1'b0, x & y};
        2'd1:    return {1'b0, x | y};
        2'd2:    return {1'b0, x ^ y};
        default: return {1'b0, ~(x | y)};
      endcase
    end
    xx = o[1] ? ~x : x;
    yy = o[0] ? ~y : y;
    return {1'b0, xx} + {1'b0, yy} + 17'(c);
  endfunction

  always_comb begin
    alu_out = alu4(alu_op, alu_a, alu_b, alu_cin);
    if (stub) alu_out = 5'h1F;
  end
  assign alu_r     = alu_out[3:0];
  assign alu_carry = alu_out[4];
  assign alu_zero  = (alu_out[3:0] == 4'h0);
  assign alu_sign  = alu_out[3];

  assign alu2_out   = alu4(alu2_op, alu2_a, alu2_b, alu2_cin);
  assign alu2_r     = alu2_out[3:0];
  assign alu2_carry = alu2_out[4];
  assign alu2_zero  = (alu2_out[3:0] == 4'h0);
  assign alu2_sign  = alu2_out[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [15:0] x, y, input logic c);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs from just after the start edge until done; edges counts the start edge as 1.
  task automatic wait_done(input bit noise, output int edges, output int busy_n, output logic [3:0] cins);
    edges = 1; busy_n = 0; cins = '0;
    while (!done && edges < 20) begin
      if (busy) busy_n++;
      if (edges <= 4) cins[edges-1] = alu_cin;
      if (noise && edges == 2) begin
        start = 1'b1; a = ~a; b = a ^ 16'h5A5A; op = ~op; cin = ~cin;
      end else begin
        start = 1'b0;
      end
      tick();
      edges++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  task automatic run_check(input logic [2:0] o, input logic [15:0] x, y, input logic c,
                           input bit noise, output logic [3:0] cins);
    logic [16:0] exp;
    logic [15:0] xx, yy;
    logic [31:0] m, s;
    logic [3:0]  cexp;
    int edges, bc;
    exp = ref_word(o, x, y, c);
    xx = o[1] ? ~x : x;
    yy = o[0] ? ~y : y;
    cexp = '0;
    cexp[0] = c;
    for (int k = 1; k < 4; k++) begin
      m = (32'd1 << (4 * k)) - 32'd1;
      s = ({16'b0, xx} & m) + ({16'b0, yy} & m) + 32'(c);
      cexp[k] = o[2] ? 1'b0 : s[4 * k];
    end
    launch(o, x, y, c);
    check("busy_after_start", busy, 1'b1);
    check("alu_op", alu_op, o);
    wait_done(noise, edges, bc, cins);
    check("latency_edges", edges, 5);
    check("busy_cycles", bc, 4);
    check("alu_cin_seq", cins, cexp);
    check("result", result, exp[15:0]);
    check("carry", carry, exp[16]);
    check("zero", zero, exp[15:0] == 16'h0);
    check("sign", sign, exp[15]);
  endtask

  initial begin
    logic [3:0] cins;
    int edges, bc, dcount;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; stub = 1'b0;
    start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0; cin2 = 1'b0;
    tick();
    tick();
    check("rst_result", result, 16'h0);
    check("rst_flags", {zero, carry, sign, busy, done}, 5'b0);
    check("rst_alu_drive", {alu_a, alu_b, alu_cin, alu_op}, 12'h0);
    check("rst_result2", result2, 8'h0);
    reset = 1'b0;
    tick();

    // Basic add
    run_check(3'b000, 16'h1234, 16'h0FCF, 1'b0, 1'b0, cins);
    check("tp_add_result", result, 16'h2203);
    tick();
    tick();

    // Full carry ripple to zero
    run_check(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, cins);
    check("tp_ripple_cins", cins, 4'b1110);
    check("tp_ripple_flags", {zero, carry, sign}, 3'b110);
    tick();

    // Stub ALU: constant F with carry, logic op masks the chain and the carry flag
    stub = 1'b1;
    launch(3'b101, 16'h1357, 16'h2468, 1'b0);
    wait_done(1'b0, edges, bc, cins);
    check("stub_latency", edges, 5);
    check("stub_cins", cins, 4'b0000);
    check("stub_result", result, 16'hFFFF);
    check("stub_flags", {zero, carry, sign}, 3'b001);
    stub = 1'b0;
    tick();

    // Start during RUN ignored, then back-to-back start in the DONE cycle
    run_check(3'b000, 16'h0F0F, 16'h0101, 1'b1, 1'b1, cins);
    check("ignore_result", result, 16'h1011);
    run_check(3'b001, 16'h5000, 16'h1000, 1'b1, 1'b0, cins);
    check("b2b_result", result, 16'h4000);
    tick();

    // Reset in the third RUN cycle discards the operation
    launch(3'b000, 16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_result", result, 16'h0);
    check("midrst_flags", {zero, carry, sign, busy, done}, 5'b0);
    check("midrst_alu_drive", {alu_a, alu_b, alu_cin, alu_op}, 12'h0);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    check("midrst_no_done", dcount, 0);
    run_check(3'b000, 16'h0001, 16'h0001, 1'b0, 1'b0, cins);
    check("midrst_fresh", result, 16'h0002);

    // Random operations, mostly back-to-back, some with idle gaps or ignored starts
    for (int i = 0; i < 40; i++) begin
      run_check(3'($urandom_range(7, 0)), 16'($urandom), 16'($urandom),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), cins);
      if ($urandom_range(3, 0) == 0) begin
        tick();
        check("rand_idle_hold", busy, 1'b0);
      end
    end
    run_check(3'b001, 16'h8000, 16'h8000, 1'b1, 1'b0, cins);
    check("sub_equal_zero", {zero, carry}, 2'b11);
    tick();

    // Two-nibble instance
    op2 = 3'b000; a2 = 8'h80; b2 = 8'h80; cin2 = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    edges = 1;
    while (!done2 && edges < 20) begin
      tick();
      edges++;
    end
    check("n2_latency", edges, 3);
    check("n2_result", result2, 8'h00);
    check("n2_flags", {zero2, carry2, sign2}, 3'b110);

    op2 = 3'b000; a2 = 8'h3C; b2 = 8'h45; cin2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    edges = 1;
    while (!done2 && edges < 20) begin
      tick();
      edges++;
    end
    check("n2b_latency", edges, 3);
    check("n2b_result", result2, 8'h82);
    check("n2b_flags", {zero2, carry2, sign2}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
